// File: rtl/adder_64bit_seq_ctrl_if.sv
// Operand/result handshake bundle for adder_64bit_seq_ctrl.
// Sub exists only when ADDSEQ_SUB_EN is defined.
interface adder_64bit_seq_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef ADDSEQ_SUB_EN
  logic             Sub;
`endif
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Busy;

`ifdef ADDSEQ_SUB_EN
  modport master (
    output In_valid, A, B, Cin, Sub, Out_ready,
    input  In_ready, Out_valid, Sum, Cout, Ovf, Busy
  );
  modport slave (
    input  In_valid, A, B, Cin, Sub, Out_ready,
    output In_ready, Out_valid, Sum, Cout, Ovf, Busy
  );
`else
  modport master (
    output In_valid, A, B, Cin, Out_ready,
    input  In_ready, Out_valid, Sum, Cout, Ovf, Busy
  );
  modport slave (
    input  In_valid, A, B, Cin, Out_ready,
    output In_ready, Out_valid, Sum, Cout, Ovf, Busy
  );
`endif
endinterface

// File: rtl/adder_64bit_seq_ctrl.sv
// Byte-serial adder: one 8-bit slice reused over WIDTH/8 cycles.
// Optional subtract path enabled by defining ADDSEQ_SUB_EN.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module adder_64bit_seq_ctrl #(
  parameter int WIDTH = 64
) (
  input logic Clk,
  input logic Reset_n,
  adder_64bit_seq_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 8;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic             sub_in;
  logic [IDXW+2:0]  base;
  logic [7:0]       s_a;
  logic [7:0]       s_b;
  logic [7:0]       s_sum;
  logic             s_cout;
  logic             last;

`ifdef ADDSEQ_SUB_EN
  assign sub_in = bus.Sub;
`else
  assign sub_in = 1'b0;
`endif

  assign base = {idx_q, 3'b000};
  assign s_a  = a_q[base +: 8];
  assign s_b  = b_q[base +: 8];
  assign last = (idx_q == IDXW'(NSLICE - 1));

  adder_8bit u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state, slice sequencing and handshake outputs.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.In_valid) begin
          state_d = RUN;
          a_d     = bus.A;
          b_d     = sub_in ? ~bus.B : bus.B;
          carry_d = sub_in ? 1'b1 : bus.Cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        busy             = 1'b1;
        sum_d[base +: 8] = s_sum;
        carry_d          = s_cout;
        idx_d            = idx_q + IDXW'(1);
        if (last) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = s_cout;
          ovf_d   = (a_q[WIDTH-1] & b_q[WIDTH-1] & ~s_sum[7]) |
                    (~a_q[WIDTH-1] & ~b_q[WIDTH-1] & s_sum[7]);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (bus.Out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = out_valid;
  assign bus.Busy      = busy;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_adder_64bit_seq_ctrl.sv
// Scoreboard bench for adder_64bit_seq_ctrl.
// Subtract case runs only when ADDSEQ_SUB_EN is defined.
module tb_adder_64bit_seq_ctrl;
  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;
  res_t exp_q[$];

  adder_64bit_seq_ctrl_if #(.WIDTH(64)) bus ();

  adder_64bit_seq_ctrl #(.WIDTH(64)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] bb;
    logic [64:0] full;
    res_t r;
    bb = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {64'b0, (sub ? 1'b1 : cin)};
    r.sum = full[63:0];
    r.cout = full[64];
    r.ovf = (a[63] & bb[63] & ~full[63]) | (~a[63] & ~bb[63] & full[63]);
    return r;
  endfunction

  // Waits for In_ready, accepts one operation, pushes its expected result.
  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sub);
    int k;
    k = 0;
    @(negedge Clk);
    while (!bus.In_ready && k < 30) begin
      @(negedge Clk);
      k++;
    end
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
`ifdef ADDSEQ_SUB_EN
    bus.Sub = sub;
`endif
    bus.In_valid = 1'b1;
    exp_q.push_back(model(a, b, cin, sub));
    @(posedge Clk);
    #1;
    bus.In_valid = 1'b0;
    bus.A = {$urandom, $urandom};
    bus.B = {$urandom, $urandom};
    bus.Cin = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
    bus.Sub = 1'($urandom);
`endif
  endtask

  // Waits (bounded) for Out_valid; returns observed and popped expected.
  task automatic wait_out(input bit consume, output bit ok, output res_t got,
                          output res_t exp, output int lat,
                          output bit rdy_seen);
    ok = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    got = '0;
    exp = '0;
    for (int k = 1; k <= 40 && !ok; k++) begin
      @(negedge Clk);
      if (bus.Out_valid) begin
        ok = 1'b1;
        lat = k - 1;
        got = '{bus.Sum, bus.Cout, bus.Ovf};
        if (exp_q.size() > 0) exp = exp_q.pop_front();
      end else if (bus.In_ready) begin
        rdy_seen = 1'b1;
      end
    end
    if (ok && bus.In_ready) rdy_seen = 1'b1;
    if (consume && ok) begin
      bus.Out_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      bus.Out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #12;
    checks++;
    if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0 ||
        bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               bus.In_ready, bus.Out_valid, bus.Busy);
    end
    checks++;
    if (bus.Sum !== 64'h0 || bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: sum=%h cout=%b ovf=%b, want 0 0 0",
               bus.Sum, bus.Cout, bus.Ovf);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok, rdy;
    res_t got, exp;
    int lat;
    send(64'h1, 64'h2, 1'b0, 1'b0);
    wait_out(1'b1, ok, got, exp, lat, rdy);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: no Out_valid within bound");
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, want 8", lat);
    end
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_in_ready: In_ready seen high during RUN/DONE");
    end
    checks++;
    if (got !== exp || got.sum !== 64'h3 || got.cout !== 1'b0 ||
        got.ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %h/%b/%b, want 3/0/0",
               got.sum, got.cout, got.ovf);
    end
    checks++;
    if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_consume: in_ready=%b out_valid=%b, want 1 0",
               bus.In_ready, bus.Out_valid);
    end
  endtask

  task automatic test_ripple();
    bit ok, rdy;
    res_t got, exp;
    int lat;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    wait_out(1'b1, ok, got, exp, lat, rdy);
    checks++;
    if (!ok || got !== exp || got.sum !== 64'h0 || got.cout !== 1'b1 ||
        got.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ripple: ok=%b got %h/%b/%b, want 0/1/0",
               ok, got.sum, got.cout, got.ovf);
    end
  endtask

  task automatic test_overflow();
    bit ok, rdy;
    res_t got, exp;
    int lat;
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_out(1'b1, ok, got, exp, lat, rdy);
    checks++;
    if (!ok || got !== exp || got.sum !== 64'h8000_0000_0000_0000 ||
        got.cout !== 1'b0 || got.ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ok=%b got %h/%b/%b, want 8000000000000000/0/1",
               ok, got.sum, got.cout, got.ovf);
    end
  endtask

  task automatic test_backpressure();
    bit ok, rdy;
    res_t got, exp, held;
    int lat;
    bit stable;
    send(64'h1234_5678_9ABC_DEF0, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 1'b0);
    wait_out(1'b0, ok, got, exp, lat, rdy);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL bp_result: ok=%b got %h/%b/%b, want %h/%b/%b",
               ok, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.In_valid = i[0];
      bus.A = {$urandom, $urandom};
      @(negedge Clk);
      held = '{bus.Sum, bus.Cout, bus.Ovf};
      if (!bus.Out_valid || bus.In_ready || held !== got) stable = 1'b0;
    end
    bus.In_valid = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stable: outputs changed or state left DONE");
    end
    bus.Out_ready = 1'b1;
    @(negedge Clk);
    bus.Out_ready = 1'b0;
    checks++;
    if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0 ||
        bus.Sum !== got.sum) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b sum=%h, want 1 0 %h",
               bus.In_ready, bus.Out_valid, bus.Sum, got.sum);
    end
    send(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b0, 1'b0);
    wait_out(1'b1, ok, got, exp, lat, rdy);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL bp_second: ok=%b got %h/%b/%b, want %h/%b/%b",
               ok, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok, rdy;
    res_t got, exp;
    int lat;
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    repeat (4) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    checks++;
    if (bus.Busy !== 1'b0 || bus.Out_valid !== 1'b0 || bus.Sum !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b out_valid=%b sum=%h, want 0 0 0",
               bus.Busy, bus.Out_valid, bus.Sum);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    wait_out(1'b1, ok, got, exp, lat, rdy);
    checks++;
    if (!ok || got !== exp) begin
      errors++;
      $display("FAIL mid_reset_after: ok=%b got %h/%b/%b, want %h/%b/%b",
               ok, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, rdy;
    res_t got, exp;
    int lat;
    logic [63:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i == 0) begin
        a = 64'h8000_0000_0000_0000;
        b = 64'h8000_0000_0000_0000;
      end
      send(a, b, 1'($urandom), 1'b0);
      wait_out(1'b1, ok, got, exp, lat, rdy);
      checks++;
      if (!ok || got !== exp || lat !== 8) begin
        errors++;
        $display("FAIL b2b_%0d: ok=%b lat=%0d got %h/%b/%b, want %h/%b/%b",
                 i, ok, lat, got.sum, got.cout, got.ovf,
                 exp.sum, exp.cout, exp.ovf);
      end
    end
  endtask

`ifdef ADDSEQ_SUB_EN
  task automatic test_sub();
    bit ok, rdy;
    res_t got, exp;
    int lat;
    send(64'h5, 64'h7, 1'b0, 1'b1);
    wait_out(1'b1, ok, got, exp, lat, rdy);
    checks++;
    if (!ok || got !== exp || got.sum !== 64'hFFFF_FFFF_FFFF_FFFE ||
        got.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: ok=%b got %h/%b, want fffffffffffffffe/0",
               ok, got.sum, got.cout);
    end
    send(64'h9, 64'h7, 1'b0, 1'b1);
    wait_out(1'b1, ok, got, exp, lat, rdy);
    checks++;
    if (!ok || got !== exp || got.sum !== 64'h2 || got.cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: ok=%b got %h/%b, want 2/1",
               ok, got.sum, got.cout);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    bus.In_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
`ifdef ADDSEQ_SUB_EN
    bus.Sub = 1'b0;
`endif
    bus.Out_ready = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef ADDSEQ_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_64bit_seq_ctrl.md
# adder_64bit_seq_ctrl

Byte-serial 64-bit add controller that time-multiplexes one internal `adder_8bit` instance over eight cycles. It replaces the area of a full ripple-carry `adder_64bit` where throughput is not critical. A valid/ready handshake accepts operands; the block sequences the low byte first through the high byte, carrying between slices in a register. It then holds the 64-bit result until the consumer accepts it.

## Interface
- `WIDTH`, 64: operand width. Must be a multiple of 8. The slice count is `NSLICE = WIDTH/8`.
- `Clk`  in  1: single clock. Rising-edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `In_valid`  in  1: operands and `Cin` are valid.
- `In_ready`  out  1: block can accept operands. High only in IDLE.
- `A`, `B`  in  WIDTH: operands, sampled on the accept edge.
- `Cin`  in  1: carry-in, sampled on the accept edge.
- `Out_valid`  out  1: `Sum`, `Cout` and `Ovf` are valid.
- `Out_ready`  in  1: consumer accepts the result.
- `Sum`  out  WIDTH: result register.
- `Cout`  out  1: carry out of bit WIDTH-1.
- `Ovf`  out  1: two's-complement overflow, computed as carry into MSB XOR carry out of MSB.
- `Busy`  out  1: high in RUN and DONE.

## Operation
- States:
  - IDLE: `In_ready`=1.
  - RUN: `idx` counts 0..NSLICE-1.
  - DONE: `Out_valid`=1.
- IDLE → RUN on an edge where `In_valid`&`In_ready`. On that edge:
  - latch A and B into operand registers;
  - carry register ← `Cin`;
  - `idx` ← 0;
  - `Sum`, `Cout` and `Ovf` ← 0.
- Each RUN cycle:
  - the internal `adder_8bit` computes A_r[8·idx+7:8·idx] + B_r[8·idx+7:8·idx] + carry.
  - On the edge, `Sum`[8·idx+7:8·idx] ← slice sum, carry ← slice Cout, and `idx` increments.
- RUN → DONE on the edge that writes slice NSLICE-1. On that edge:
  - `Cout` ← slice Cout;
  - `Ovf` ← A_r[MSB] & B_r[MSB] & ~Sum_msb | ~A_r[MSB] & ~B_r[MSB] & Sum_msb.
- DONE → IDLE on an edge where `Out_valid`&`Out_ready`. `Sum`, `Cout` and `Ovf` keep their values until the next accept.
- `In_valid` in RUN or DONE is ignored. Inputs A, B and Cin may change freely after the accept edge.
- `Out_ready` outside DONE is ignored.
- Arithmetic is modulo 2^WIDTH. `Cout` and `Ovf` report the wrap.

## Timing
- Reset (asynchronous, takes effect immediately) sets:
  - state IDLE;
  - `In_ready`=1;
  - `Out_valid`=0, `Busy`=0;
  - `Sum`=0, `Cout`=0, `Ovf`=0;
  - `idx`=0, carry=0.
- Reset mid-RUN or in DONE aborts the operation; no result is produced.
- Latency: with accept on edge E0, `Out_valid` rises after edge E(NSLICE). For the default width this is 8 cycles.
- `Out_valid`, `Sum`, `Cout` and `Ovf` are stable while `Out_valid`=1 and `Out_ready`=0.
- Accept and result-consume never coincide, because `In_ready`=0 in DONE. `In_ready` returns high in the cycle after the consume edge.
- Minimum initiation interval is NSLICE+2 cycles: 10 at the default width, with `Out_ready` held high.
- `Sum` bits are meaningful only while `Out_valid`=1. Partial bytes are visible during RUN and must not be checked.

## Configuration
- `ADDSEQ_SUB_EN`
  - Defined: adds input `Sub` (in, 1), sampled on the accept edge with A and B.
    - With `Sub`=1, the B register is loaded with ~B and the carry register with 1, regardless of `Cin`.
    - `Sum` = A−B mod 2^WIDTH, and `Cout`=1 means no borrow.
    - With `Sub`=0, behaviour is identical to the add path.
  - Undefined: no `Sub` port; add only.

## Test plan
- Reset, then A=0x0000_0000_0000_0001, B=0x0000_0000_0000_0002, Cin=0, accept at E0 → `Out_valid` after E8:
  - `Sum`=0x3, `Cout`=0, `Ovf`=0;
  - `In_ready`=0 throughout E1..consume.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 (carry ripples through all slices) → `Sum`=0, `Cout`=1, `Ovf`=0.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1, Cin=0 → `Sum`=0x8000_0000_0000_0000, `Cout`=0, `Ovf`=1.
- Back-pressure: hold `Out_ready`=0 for 5 cycles in DONE → outputs stable and `In_valid` pulses ignored; raise `Out_ready` → IDLE next cycle, and a new accept yields a correct second result.
- Assert `Reset_n`=0 at RUN idx=4 → immediately `Busy`=0, `Out_valid`=0, `Sum`=0; the subsequent operation completes correctly.
- With `ADDSEQ_SUB_EN` defined: A=5, B=7, Sub=1 → `Sum`=0xFFFF_FFFF_FFFF_FFFE, `Cout`=0.
